// File: rtl/hdd_insert_filter.sv
// Debounces HDD carrier-presence pins into clean HDDn_INSERT_L, latches sticky per-bay change flags
// with write-1-to-clear, and raises an active-low interrupt while any flag is set.
module hdd_insert_filter #(
    parameter int NUM_HDD  = 15,
    parameter int TICK_DIV = 25000,
    parameter int DEB_CNT  = 20
) (
    input  logic               SYSCLK,
    input  logic               RESET,
    input  logic [NUM_HDD-1:0] HDD_INSERT_RAW_L,
    input  logic [NUM_HDD-1:0] EVT_CLR,
    output logic [NUM_HDD-1:0] HDD_INSERT_L,
    output logic [NUM_HDD-1:0] HDD_INSERT_EVT,
    output logic               HDD_CHG_INT_L,
    output logic               SAMPLE_TICK
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(DEB_CNT + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEB_CNT - 1);

    localparam logic [0:0] ST_STABLE  = 1'b0;
    localparam logic [0:0] ST_CONFIRM = 1'b1;

    logic [NUM_HDD-1:0]         sync1_q, sync2_q;
    logic [PW-1:0]              presc_q, presc_d;
    logic [NUM_HDD-1:0]         state_q, state_d;
    logic [NUM_HDD-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_HDD-1:0]         out_q, out_d;
    logic [NUM_HDD-1:0]         evt_q, evt_d;
    logic                       int_l_q;
    logic [NUM_HDD-1:0]         toggle;
    logic                       tick;

    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        toggle  = '0;
        if (tick) begin
            for (int i = 0; i < NUM_HDD; i++) begin
                case (state_q[i])
                    ST_STABLE: begin
                        if (sync2_q[i] != out_q[i]) begin
                            // A single-tick debounce needs no confirmation phase.
                            if (DEB_CNT == 1) begin
                                toggle[i] = 1'b1;
                            end else begin
                                cnt_d[i]   = CW'(1);
                                state_d[i] = ST_CONFIRM;
                            end
                        end else begin
                            cnt_d[i] = '0;
                        end
                    end
                    default: begin
                        if (sync2_q[i] == out_q[i]) begin
                            cnt_d[i]   = '0;
                            state_d[i] = ST_STABLE;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            toggle[i]  = 1'b1;
                            cnt_d[i]   = '0;
                            state_d[i] = ST_STABLE;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                endcase
            end
        end
        out_d = out_q ^ toggle;
        // A new toggle overrides a clear strobe landing in the same cycle.
        evt_d = (evt_q & ~EVT_CLR) | toggle;
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            sync1_q <= '1;
            sync2_q <= '1;
            presc_q <= '0;
            state_q <= {NUM_HDD{ST_STABLE}};
            cnt_q   <= '0;
            out_q   <= '1;
            evt_q   <= '0;
            int_l_q <= 1'b1;
        end else begin
            sync1_q <= HDD_INSERT_RAW_L;
            sync2_q <= sync1_q;
            presc_q <= presc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            evt_q   <= evt_d;
            int_l_q <= ~|evt_q;
        end
    end

    assign HDD_INSERT_L   = out_q;
    assign HDD_INSERT_EVT = evt_q;
    assign HDD_CHG_INT_L  = int_l_q;
    assign SAMPLE_TICK    = tick;

endmodule
